// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT output reorder stage.
// Bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
package fft_pkg;

  localparam int N_LOG2_DEF = 5;
  localparam int DW_DEF = 16;
  localparam int FRAME_LEN = 1 << N_LOG2_DEF;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_t;

endpackage

// File: rtl/fft_out_reorder_if.sv
// Stream bundle for the reorder stage: FFT sample input side,
// valid/ready natural-order output side and the overflow pulse.
interface fft_out_reorder_if
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DW = DW_DEF
);

  logic              in_valid;
  logic [DW-1:0]     in_i;
  logic [DW-1:0]     in_q;
  logic [N_LOG2-1:0] in_index;

  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_i;
  logic [DW-1:0]     out_q;
  logic [N_LOG2-1:0] out_index;
  logic              out_last;
  logic              overflow;

  modport master (
    output in_valid, in_i, in_q, in_index, out_ready,
    input  out_valid, out_i, out_q, out_index, out_last, overflow
  );

  modport slave (
    input  in_valid, in_i, in_q, in_index, out_ready,
    output out_valid, out_i, out_q, out_index, out_last, overflow
  );

endinterface

// File: rtl/fft_reorder_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
module fft_reorder_dpram #(
  parameter int AW = 6,
  parameter int W = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [(1 << AW)];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder of FFT output frames into natural bin order.
// FFT_REORDER_FFTSHIFT_EN: replay starts at the mid-frame bin.
module fft_out_reorder
  import fft_pkg::*;
#(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DW = DW_DEF
) (
  input  logic clk,
  input  logic reset,
  fft_out_reorder_if.slave bus
);

  localparam logic [N_LOG2-1:0] LAST = '1;
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam logic [N_LOG2-1:0] SHIFT =
    {1'b1, {(N_LOG2-1){1'b0}}};
`else
  localparam logic [N_LOG2-1:0] SHIFT = '0;
`endif

  bank_st_t st [2];
  bank_st_t wst;
  bank_st_t ist;

  logic              wr_bank;
  logic              dropping;
  logic [N_LOG2-1:0] wr_cnt;
  logic              iss_bank;
  logic              rd_bank;
  logic [N_LOG2-1:0] iss_pos;
  logic [N_LOG2-1:0] rd_addr;

  logic              a_v;
  logic              a_last;
  logic [N_LOG2-1:0] a_idx;
  logic              b_v;
  logic              b_last;
  logic [N_LOG2-1:0] b_idx;
  logic [DW-1:0]     b_i;
  logic [DW-1:0]     b_q;
  logic [2*DW-1:0]   rdata;

  logic start;
  logic ovf;
  logic wr_en;
  logic fire;
  logic a_take;
  logic iss;

  always_comb begin
    wst = st[wr_bank];
    ist = st[iss_bank];
    start = bus.in_valid && (wr_cnt == '0);
    ovf = start && (wst != EMPTY);
    wr_en = bus.in_valid && !dropping && !ovf;
    fire = bus.out_valid && bus.out_ready;
    // A empties when consumed, or when it spills into the skid slot B
    a_take = a_v && (!b_v || fire);
    iss = (ist == FULL || ist == DRAINING) && (!a_v || a_take);
    rd_addr = iss_pos ^ SHIFT;
  end

  assign bus.overflow = ovf && !reset;
  assign bus.out_valid = a_v || b_v;
  assign bus.out_i = b_v ? b_i : (a_v ? rdata[2*DW-1:DW] : '0);
  assign bus.out_q = b_v ? b_q : (a_v ? rdata[DW-1:0] : '0);
  assign bus.out_index = b_v ? b_idx : a_idx;
  assign bus.out_last = b_v ? b_last : (a_v && a_last);

  fft_reorder_dpram #(
    .AW(N_LOG2 + 1),
    .W(2 * DW)
  ) u_ram (
    .clk(clk),
    .we(wr_en),
    .waddr({wr_bank, bus.in_index}),
    .wdata({bus.in_i, bus.in_q}),
    .re(iss),
    .raddr({iss_bank, rd_addr}),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      wr_bank <= 1'b0;
      dropping <= 1'b0;
      wr_cnt <= '0;
      iss_bank <= 1'b0;
      iss_pos <= '0;
      rd_bank <= 1'b0;
      a_v <= 1'b0;
      a_last <= 1'b0;
      a_idx <= '0;
      b_v <= 1'b0;
      b_last <= 1'b0;
      b_idx <= '0;
      b_i <= '0;
      b_q <= '0;
    end else begin
      if (bus.in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (ovf) dropping <= 1'b1;
        else if (start) st[wr_bank] <= FILLING;
        if (wr_cnt == LAST) begin
          if (dropping) begin
            dropping <= 1'b0;
          end else begin
            st[wr_bank] <= FULL;
            wr_bank <= ~wr_bank;
          end
        end
      end
      // issue side runs ahead of the drain side by up to two samples
      if (iss) begin
        if (ist == FULL) st[iss_bank] <= DRAINING;
        iss_pos <= iss_pos + 1'b1;
        if (iss_pos == LAST) iss_bank <= ~iss_bank;
        a_idx <= rd_addr;
        a_last <= (iss_pos == LAST);
      end
      a_v <= iss || (a_v && !a_take);
      if (b_v ? fire : (a_v && !fire)) begin
        b_v <= a_v;
        b_i <= rdata[2*DW-1:DW];
        b_q <= rdata[DW-1:0];
        b_idx <= a_idx;
        b_last <= a_last;
      end
      if (fire && bus.out_last) begin
        st[rd_bank] <= EMPTY;
        rd_bank <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: scenario table, hand sequences and a
// randomized run against a frame-level scoreboard model.
module tb_fft_out_reorder;
  import fft_pkg::*;

  localparam int NL = 5;
  localparam int W = 16;
  localparam int FL = FRAME_LEN;
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam int SHIFT = FL / 2;
`else
  localparam int SHIFT = 0;
`endif

  typedef struct {
    logic [W-1:0]  i;
    logic [W-1:0]  q;
    logic [NL-1:0] idx;
    logic          last;
  } exp_t;

  typedef struct {
    int frames_a;
    int gap;
    int stall;
    int frames_b;
    int exp_out;
    int exp_ovf;
    int burst;
    bit lat;
  } row_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int tot = 0;
  int bad = 0;
  bit rand_rdy = 1'b0;
  logic rdy_fixed = 1'b1;

  fft_out_reorder_if #(.N_LOG2(NL), .DW(W)) bus ();

  fft_out_reorder #(.N_LOG2(NL), .DW(W)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    bus.out_ready = rand_rdy ? 1'($urandom_range(1, 0)) : rdy_fixed;
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    tot++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Frame-level model state
  exp_t exp_q[$];
  logic [W-1:0] cur_i [FL];
  logic [W-1:0] cur_q [FL];
  int m_cnt = 0;
  bit m_drop = 0;
  int held = 0;
  int out_cnt = 0;
  int ovf_seen = 0;
  int accepted = 0;
  int drops = 0;
  int first_ov = -1;
  int last_in = -1;
  int first_idx = -1;
  bit prev_stall = 0;
  logic [37:0] saved;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_cnt = 0; m_drop = 0; held = 0;
      out_cnt = 0; ovf_seen = 0; accepted = 0; drops = 0;
      first_ov = -1; last_in = -1; first_idx = -1;
      prev_stall = 0;
    end else begin
      bit done_last;
      exp_t e;
      done_last = 0;
      if (bus.overflow) ovf_seen++;
      if (first_ov < 0 && bus.out_valid) first_ov = cyc;
      if (prev_stall)
        chk("hold", {bus.out_valid, bus.out_i, bus.out_q,
                     bus.out_index, bus.out_last}, {1'b1, saved});
      prev_stall = bus.out_valid && !bus.out_ready;
      saved = {bus.out_i, bus.out_q, bus.out_index, bus.out_last};
      if (bus.out_valid && bus.out_ready) begin
        out_cnt++;
        if (first_idx < 0) first_idx = int'(bus.out_index);
        if (exp_q.size() == 0) begin
          tot++; bad++;
          $display("FAIL extra_out: got bin %0d want none", bus.out_index);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {bus.out_i, bus.out_q, bus.out_index,
                           bus.out_last}, {e.i, e.q, e.idx, e.last});
          done_last = e.last;
        end
      end
      if (bus.in_valid) begin
        if (m_cnt == 0) begin
          m_drop = (held >= 2);
          chk("ovf_at_start", 64'(bus.overflow), 64'(m_drop));
          if (m_drop) drops++;
          else begin held++; accepted++; end
        end
        if (!m_drop) begin
          cur_i[bus.in_index] = bus.in_i;
          cur_q[bus.in_index] = bus.in_q;
        end
        m_cnt++;
        if (m_cnt == FL) begin
          m_cnt = 0;
          if (!m_drop) begin
            if (last_in < 0) last_in = cyc;
            for (int p = 0; p < FL; p++) begin
              int b;
              b = p ^ SHIFT;
              e.i = cur_i[b]; e.q = cur_q[b];
              e.idx = NL'(b); e.last = (p == FL - 1);
              exp_q.push_back(e);
            end
          end
          m_drop = 0;
        end
      end
      if (done_last) held--;
    end
  end

  function automatic logic [NL-1:0] rev(input logic [NL-1:0] x);
    logic [NL-1:0] r;
    for (int b = 0; b < NL; b++) r[b] = x[NL-1-b];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valid", 64'(bus.out_valid), 64'(0));
    chk("reset_last_ovf", {bus.out_last, bus.overflow}, 64'(0));
    chk("reset_data", {bus.out_i, bus.out_q, bus.out_index}, 64'(0));
    tick();
  endtask

  task automatic send(input int tag, input int n, input bit rnd,
                      input int gap_pct, input bit nat);
    logic [NL-1:0] mask;
    logic [NL-1:0] idx;
    logic [W-1:0] d;
    mask = rnd ? NL'($urandom) : '0;
    for (int k = 0; k < n; k++) begin
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        bus.in_valid = 1'b0;
        tick();
      end
      idx = nat ? NL'(k) : (rev(NL'(k)) ^ mask);
      d = rnd ? W'($urandom) : W'(tag * 256 + int'(idx));
      bus.in_valid = 1'b1;
      bus.in_i = d;
      bus.in_q = -d;
      bus.in_index = idx;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 4000) begin
      tick();
      n++;
    end
    chk("drain_in_time", 64'(n < 4000), 64'(1));
  endtask

  row_t rows [4];

  initial begin
    int t0;
    int base;
    int n;
    bus.in_valid = 1'b0;
    bus.in_i = '0;
    bus.in_q = '0;
    bus.in_index = '0;
    rows[0] = '{1, 0, 0, 0, 32, 0, 0, 1'b1};
    rows[1] = '{4, 2, 0, 0, 128, 0, 0, 1'b0};
    rows[2] = '{3, 0, 100, 1, 96, 1, 64, 1'b0};
    rows[3] = '{2, 1, 80, 0, 64, 0, 64, 1'b0};

    for (int r = 0; r < 4; r++) begin
      rand_rdy = 1'b0;
      rdy_fixed = (rows[r].stall == 0);
      do_reset();
      t0 = cyc;
      for (int f = 0; f < rows[r].frames_a; f++) begin
        send(r * 16 + f, FL, 1'b0, 0, 1'b0);
        repeat (rows[r].gap) tick();
      end
      if (rows[r].stall > 0) begin
        while (cyc - t0 < rows[r].stall) tick();
        base = out_cnt;
        rdy_fixed = 1'b1;
        n = 0;
        while (out_cnt < base + rows[r].burst && n < 1000) begin
          tick();
          n++;
        end
        chk("burst_cycles", 64'(n), 64'(rows[r].burst));
      end
      wait_drain();
      for (int f = 0; f < rows[r].frames_b; f++) begin
        send(r * 16 + 8 + f, FL, 1'b0, 0, 1'b0);
      end
      wait_drain();
      chk("row_out_count", 64'(out_cnt), 64'(rows[r].exp_out));
      chk("row_ovf_count", 64'(ovf_seen), 64'(rows[r].exp_ovf));
      if (rows[r].lat)
        chk("first_latency", 64'(first_ov - last_in), 64'(2));
    end

    // natural-order input; first bin reflects the optional shift
    rdy_fixed = 1'b1;
    do_reset();
    send(8'h50, FL, 1'b0, 0, 1'b1);
    wait_drain();
    chk("first_bin", 64'(first_idx), 64'(SHIFT));
    chk("nat_count", 64'(out_cnt), 64'(FL));

    // reset while one frame drains and the next is half written
    do_reset();
    send(8'h70, FL, 1'b0, 0, 1'b0);
    n = 0;
    while (out_cnt < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_started", 64'(out_cnt >= 5), 64'(1));
    send(8'h71, 10, 1'b0, 0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", 64'(bus.out_valid), 64'(0));
    tick();
    send(8'h72, FL, 1'b0, 0, 1'b0);
    wait_drain();
    chk("post_reset_count", 64'(out_cnt), 64'(FL));

    // randomized gaps and backpressure
    do_reset();
    rand_rdy = 1'b1;
    for (int f = 0; f < 12; f++) begin
      send(0, FL, 1'b1, 30, 1'b0);
      repeat ($urandom_range(40, 0)) tick();
    end
    rand_rdy = 1'b0;
    rdy_fixed = 1'b1;
    repeat (3) tick();
    wait_drain();
    chk("rand_out_count", 64'(out_cnt), 64'(accepted * FL));
    chk("rand_ovf_count", 64'(ovf_seen), 64'(drops));

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Downstream stage of the 32-point FFT block. Captures each FFT output frame (16-bit I/Q plus 5-bit bin index, arriving in arbitrary, typically bit-reversed, order) into a ping-pong buffer. It replays completed frames in natural bin order over a valid/ready stream. The FFT core cannot be stalled, so the block absorbs one frame while the previous one drains, and drops whole frames on overrun.

## Interface
Parameters:
- N_LOG2, 5, log2 of FFT points (frame length 2^N_LOG2)
- DW, 16, I and Q sample width

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  FFT output sample present this cycle
- in_i  in  DW  real part
- in_q  in  DW  imaginary part
- in_index  in  N_LOG2  bin index of sample (each value exactly once per frame)
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts when high with out_valid
- out_i  out  DW  real part, natural order
- out_q  out  DW  imaginary part
- out_index  out  N_LOG2  bin number of emitted sample
- out_last  out  1  high on final sample of a frame
- overflow  out  1  one-cycle pulse when a frame is dropped

## Operation
- Two banks, each 2^N_LOG2 words of {i,q}. Each bank state is EMPTY, FILLING, FULL or DRAINING.
- Write side:
  - A frame starts when in_valid and write count == 0.
  - If the selected write bank is EMPTY at that cycle, it becomes FILLING. Samples are written at address in_index, and the count increments per in_valid.
  - At count 2^N_LOG2 − 1 plus in_valid, the bank becomes FULL, the count returns to 0, and the write bank toggles.
  - If the selected bank is not EMPTY at frame start: assert overflow for that cycle and discard exactly 2^N_LOG2 in_valid samples (drop counter). Then retry at the next frame start; the bank select is unchanged.
- Read side:
  - Drains banks in fill order.
  - A FULL bank becomes DRAINING, and the read address counts 0..2^N_LOG2−1.
  - Each out_valid&&out_ready advances to the next sample.
  - The acceptance of the last sample sets the bank to EMPTY and toggles the read bank.
- out_index equals the bin emitted. out_last is high when out_index is the final read position.
- Hold rule: while out_valid && !out_ready, out_i/out_q/out_index/out_last remain stable.
- Simultaneous events:
  - A bank freed by a last-sample handshake in cycle T is seen as EMPTY by the write side from cycle T+1.
  - A frame start in cycle T on that bank overflows.
- Reset: both banks EMPTY, all counters 0, bank selects 0. Reset mid-frame discards all buffered and partial data.
- RAM contents are not reset.

## Timing
- Reset values: out_valid 0, out_last 0, overflow 0, out_i/out_q/out_index 0.
- Latency: last input sample written in cycle T → bank FULL at T+1 → first out_valid at T+2 (if the read side is idle).
- RAM read is registered (1 cycle). The read pipeline includes a 2-entry skid so that:
  - throughput is 1 sample/cycle with out_ready held high;
  - there is no bubble between consecutive frames when the next bank is already FULL.
- overflow is asserted in the same cycle as the dropped frame's first in_valid.
- in_valid may have arbitrary gaps; no requirement on contiguity.

## Configuration
- FFT_REORDER_FFTSHIFT_EN defined: read address = position XOR 2^(N_LOG2−1). DC is emitted at mid-frame, order 16..31,0..15 for N=32; out_index reports the actual bin read. out_last remains on the 32nd emitted sample.
- Undefined: natural order 0..2^N_LOG2−1.

## Structure
- Shared package fft_pkg:
  - N_LOG2 and DW defaults
  - bank-state enum {EMPTY, FILLING, FULL, DRAINING}
  - frame-length constant
- One sub-module, fft_reorder_dpram: simple dual-port RAM, 2·2^N_LOG2 × 2·DW, one write port and one registered read port. Address = {bank, index}.

## Test plan
- Bit-reversed frame, in_i=index, in_q=−index, in_valid continuous, out_ready=1 → 32 outputs, out_i 0..31 in order, out_last on index 31, first out_valid 2 cycles after final input.
- Four back-to-back frames, out_ready=1 → 128 contiguous outputs with no bubble, frame data intact, overflow never asserted.
- out_ready=0 for 100 cycles while three frames arrive → frames 1–2 buffered, overflow pulses once at frame 3 start. After release, outputs are frames 1 and 2 only, and frame 4 is accepted normally.
- Random out_ready (50%) and random in_valid gaps → scoreboard matches, outputs stable during stalls.
- reset asserted mid-drain and mid-fill → next cycle out_valid=0. The next complete frame emerges alone and correct.
- With FFT_REORDER_FFTSHIFT_EN, natural-order input → out_index sequence 16..31,0..15, out_last on out_index 15.
